regfile_multiport: RTL

- Parametrised successor to the processor's 32x32 register bank.
- Two architectural write ports: port 1 for ALU results, port 2 for load and writeback.
- Two operand read ports plus an independently addressed debug read port.
- Sequential clear engine zeroes the array after reset.
- Optional hardwired-zero register 0 and optional same-cycle write-to-read bypass.
- Sits between decode (read addresses) and writeback in the single-cycle and multicycle datapaths.

---
 rtl/regfile_multiport.sv | 94 +++++++++
 1 files changed

// File: rtl/regfile_multiport.sv
// Multiport register bank: two write ports, two operand read ports, one debug read port.
// A clear engine zeroes the array after reset. Define REGFILE_BYPASS_EN for same-cycle forwarding.
module regfile_multiport #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ZERO_R0  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rc,
  input  logic [DATA_W-1:0] write,
  input  logic              writeReg,
  input  logic [ADDR_W-1:0] rc2,
  input  logic [DATA_W-1:0] write2,
  input  logic              writeReg2,
  output logic [DATA_W-1:0] readA,
  output logic [DATA_W-1:0] readB,
  output logic [DATA_W-1:0] debug,
  output logic              busy
);

  localparam logic [ADDR_W:0]   NumRegsW = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {StClear, StReady} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic [DATA_W-1:0] mem_q [NUM_REGS];

  logic we1, we2;

  // An address is live when it names a real register that is not the hardwired zero.
  function automatic logic addr_live(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < NumRegsW) && !((ZERO_R0 != 0) && (addr == '0));
  endfunction

  assign we1  = writeReg  && !busy_q && addr_live(rc);
  assign we2  = writeReg2 && !busy_q && addr_live(rc2);
  assign busy = busy_q;

  // All state moves on the falling edge so the datapath writes early and reads late.
  always_ff @(negedge clock) begin
    if (reset) begin
      state_q <= StClear;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StClear: begin
          mem_q[cnt_q] <= '0;
          if (cnt_q == LastIdx) begin
            state_q <= StReady;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StReady: begin
          // Port 1 is assigned last so it wins an address collision.
          if (we2) mem_q[rc2] <= write2;
          if (we1) mem_q[rc]  <= write;
        end
      endcase
    end
  end

  always_comb begin
    readA = '0;
    readB = '0;
    debug = '0;
    if (!busy_q) begin
      if (addr_live(ra)) readA = mem_q[ra];
      if (addr_live(rb)) readB = mem_q[rb];
      if (addr_live(rd)) debug = mem_q[rd];
`ifdef REGFILE_BYPASS_EN
      if (addr_live(ra)) begin
        if (we1 && (rc == ra))       readA = write;
        else if (we2 && (rc2 == ra)) readA = write2;
      end
      if (addr_live(rb)) begin
        if (we1 && (rc == rb))       readB = write;
        else if (we2 && (rc2 == rb)) readB = write2;
      end
`endif
    end
  end

endmodule
